// File: rtl/ex_stage_if.sv
// Bundle of the ID/EX-side inputs and EX-side results of the execute stage.
// The master drives the decoded instruction fields and forwarding controls.
// The slave is the execute stage, which returns the ALU result, flags and branch decision.
interface ex_stage_if #(
  parameter int WIDTH   = 8,
  parameter int FLAGS_W = 4
);
  logic               stall;
  logic               flush_Ex;
  logic [3:0]         Alu_Op_Ex;
  logic               SaveFlags_Ex;
  logic               returnF_Ex;
  logic [2:0]         br_type_Ex;
  logic [WIDTH-1:0]   R_ra_Ex;
  logic [WIDTH-1:0]   R_rb_Ex;
  logic [1:0]         fwd_a_sel;
  logic [1:0]         fwd_b_sel;
  logic [WIDTH-1:0]   fwd_mem_data;
  logic [WIDTH-1:0]   fwd_wb_data;
  logic [WIDTH-1:0]   alu_out_Ex;
  logic [WIDTH-1:0]   op_b_Ex;
  logic [FLAGS_W-1:0] ccr;
  logic [FLAGS_W-1:0] saved_ccr;
  logic               branch_taken;
  logic [WIDTH-1:0]   branch_target;

  modport master (
    output stall, flush_Ex, Alu_Op_Ex, SaveFlags_Ex, returnF_Ex, br_type_Ex,
           R_ra_Ex, R_rb_Ex, fwd_a_sel, fwd_b_sel, fwd_mem_data, fwd_wb_data,
    input  alu_out_Ex, op_b_Ex, ccr, saved_ccr, branch_taken, branch_target
  );

  modport slave (
    input  stall, flush_Ex, Alu_Op_Ex, SaveFlags_Ex, returnF_Ex, br_type_Ex,
           R_ra_Ex, R_rb_Ex, fwd_a_sel, fwd_b_sel, fwd_mem_data, fwd_wb_data,
    output alu_out_Ex, op_b_Ex, ccr, saved_ccr, branch_taken, branch_target
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, 8-bit ALU, condition-code register
// {V,C,N,Z}, interrupt flag save/restore and conditional-jump resolution.
module ex_stage #(
  parameter int WIDTH   = 8,
  parameter int FLAGS_W = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  ex_stage_if.slave bus
);

  // Flag bit positions inside the CCR
  localparam int FV = 3;
  localparam int FC = 2;
  localparam int FN = 1;
  localparam int FZ = 0;

  localparam logic [3:0] OP_PASS = 4'd0;
  localparam logic [3:0] OP_MOV  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_RLC  = 4'd6;
  localparam logic [3:0] OP_RRC  = 4'd7;
  localparam logic [3:0] OP_SETC = 4'd8;
  localparam logic [3:0] OP_CLRC = 4'd9;
  localparam logic [3:0] OP_NOT  = 4'd10;
  localparam logic [3:0] OP_NEG  = 4'd11;
  localparam logic [3:0] OP_INC  = 4'd12;
  localparam logic [3:0] OP_DEC  = 4'd13;

  localparam logic [2:0] BR_JZ  = 3'd1;
  localparam logic [2:0] BR_JN  = 3'd2;
  localparam logic [2:0] BR_JC  = 3'd3;
  localparam logic [2:0] BR_JV  = 3'd4;
  localparam logic [2:0] BR_JMP = 3'd5;

  localparam logic [WIDTH:0] ONE_EXT = (WIDTH+1)'(1);

  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH-1:0]   alu_out;
  logic [WIDTH:0]     sum_ext;
  logic               zn_update;
  logic [FLAGS_W-1:0] alu_flags;
  logic [FLAGS_W-1:0] clear_mask;
  logic               branch_cond;
  logic               taken;
  logic [FLAGS_W-1:0] ccr_next;
  logic [FLAGS_W-1:0] ccr_reg;
  logic [FLAGS_W-1:0] saved_reg;

  // Forwarding muxes for both operands (select 3 falls back to the register file)
  always_comb begin
    case (bus.fwd_a_sel)
      2'd1:    op_a = bus.fwd_mem_data;
      2'd2:    op_a = bus.fwd_wb_data;
      default: op_a = bus.R_ra_Ex;
    endcase
    case (bus.fwd_b_sel)
      2'd1:    op_b = bus.fwd_mem_data;
      2'd2:    op_b = bus.fwd_wb_data;
      default: op_b = bus.R_rb_Ex;
    endcase
  end

  // ALU result and the flag word it would produce; untouched flags keep the CCR value
  always_comb begin
    alu_out   = op_a;
    sum_ext   = '0;
    zn_update = 1'b0;
    alu_flags = ccr_reg;
    case (bus.Alu_Op_Ex)
      OP_PASS: alu_out = op_a;
      OP_MOV:  alu_out = op_b;
      OP_ADD: begin
        sum_ext       = {1'b0, op_a} + {1'b0, op_b};
        alu_out       = sum_ext[WIDTH-1:0];
        alu_flags[FC] = sum_ext[WIDTH];
        alu_flags[FV] = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (alu_out[WIDTH-1] != op_a[WIDTH-1]);
        zn_update     = 1'b1;
      end
      OP_SUB: begin
        // The extra top bit of the extended difference is the borrow (A < B unsigned)
        sum_ext       = {1'b0, op_a} - {1'b0, op_b};
        alu_out       = sum_ext[WIDTH-1:0];
        alu_flags[FC] = sum_ext[WIDTH];
        alu_flags[FV] = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (alu_out[WIDTH-1] != op_a[WIDTH-1]);
        zn_update     = 1'b1;
      end
      OP_AND: begin
        alu_out   = op_a & op_b;
        zn_update = 1'b1;
      end
      OP_OR: begin
        alu_out   = op_a | op_b;
        zn_update = 1'b1;
      end
      OP_RLC: begin
        alu_out       = {op_b[WIDTH-2:0], ccr_reg[FC]};
        alu_flags[FC] = op_b[WIDTH-1];
      end
      OP_RRC: begin
        alu_out       = {ccr_reg[FC], op_b[WIDTH-1:1]};
        alu_flags[FC] = op_b[0];
      end
      OP_SETC: begin
        alu_out       = op_b;
        alu_flags[FC] = 1'b1;
      end
      OP_CLRC: begin
        alu_out       = op_b;
        alu_flags[FC] = 1'b0;
      end
      OP_NOT: begin
        alu_out   = ~op_b;
        zn_update = 1'b1;
      end
      OP_NEG: begin
        alu_out   = '0 - op_b;
        zn_update = 1'b1;
      end
      OP_INC: begin
        sum_ext       = {1'b0, op_b} + ONE_EXT;
        alu_out       = sum_ext[WIDTH-1:0];
        alu_flags[FC] = sum_ext[WIDTH];
        alu_flags[FV] = !op_b[WIDTH-1] && alu_out[WIDTH-1];
        zn_update     = 1'b1;
      end
      OP_DEC: begin
        sum_ext       = {1'b0, op_b} - ONE_EXT;
        alu_out       = sum_ext[WIDTH-1:0];
        alu_flags[FC] = sum_ext[WIDTH];
        alu_flags[FV] = op_b[WIDTH-1] && !alu_out[WIDTH-1];
        zn_update     = 1'b1;
      end
      default: alu_out = op_a;
    endcase
    if (zn_update) begin
      alu_flags[FZ] = (alu_out == '0);
      alu_flags[FN] = alu_out[WIDTH-1];
    end
  end

  // Branch resolution against the committed CCR; a taken conditional jump consumes its flag
  always_comb begin
    branch_cond = 1'b0;
    clear_mask  = '0;
    case (bus.br_type_Ex)
      BR_JZ: begin
        branch_cond    = ccr_reg[FZ];
        clear_mask[FZ] = 1'b1;
      end
      BR_JN: begin
        branch_cond    = ccr_reg[FN];
        clear_mask[FN] = 1'b1;
      end
      BR_JC: begin
        branch_cond    = ccr_reg[FC];
        clear_mask[FC] = 1'b1;
      end
      BR_JV: begin
        branch_cond    = ccr_reg[FV];
        clear_mask[FV] = 1'b1;
      end
      BR_JMP:  branch_cond = 1'b1;
      default: branch_cond = 1'b0;
    endcase
    taken    = branch_cond && !bus.flush_Ex;
    ccr_next = taken ? (alu_flags & ~clear_mask) : alu_flags;
  end

  // CCR and saved flags: stall/flush hold both, return restores, save captures the pre-edge CCR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccr_reg   <= '0;
      saved_reg <= '0;
    end else if (!bus.stall && !bus.flush_Ex) begin
      ccr_reg <= bus.returnF_Ex ? saved_reg : ccr_next;
      if (bus.SaveFlags_Ex) begin
        saved_reg <= ccr_reg;
      end
    end
  end

  assign bus.alu_out_Ex    = alu_out;
  assign bus.op_b_Ex       = op_b;
  assign bus.ccr           = ccr_reg;
  assign bus.saved_ccr     = saved_reg;
  assign bus.branch_taken  = taken;
  assign bus.branch_target = op_b;

endmodule

// File: tb/tb_ex_stage.sv
// Directed, table-driven bench for ex_stage: each record is one instruction
// with its expected combinational results and the flag state after the edge.
module tb_ex_stage;

  typedef struct {
    logic [3:0] op;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [1:0] asel;
    logic [1:0] bsel;
    logic [7:0] mem;
    logic [7:0] wb;
    logic [2:0] br;
    logic [3:0] ctl;     // {stall, flush, save, return}
    logic [7:0] e_out;
    logic [7:0] e_opb;
    logic       e_taken;
    logic [3:0] e_ccr;
    logic [3:0] e_saved;
  } vec_t;

  localparam int NVEC = 36;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs [NVEC];

  ex_stage_if bus ();

  ex_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic [3:0] op, input logic [7:0] ra, input logic [7:0] rb,
    input logic [1:0] asel, input logic [1:0] bsel,
    input logic [7:0] mem, input logic [7:0] wb, input logic [2:0] br,
    input logic [3:0] ctl, input logic [7:0] e_out, input logic [7:0] e_opb,
    input logic e_taken, input logic [3:0] e_ccr, input logic [3:0] e_saved);
    vec_t v;
    v.op = op; v.ra = ra; v.rb = rb; v.asel = asel; v.bsel = bsel;
    v.mem = mem; v.wb = wb; v.br = br; v.ctl = ctl;
    v.e_out = e_out; v.e_opb = e_opb; v.e_taken = e_taken;
    v.e_ccr = e_ccr; v.e_saved = e_saved;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.Alu_Op_Ex    = v.op;
    bus.R_ra_Ex      = v.ra;
    bus.R_rb_Ex      = v.rb;
    bus.fwd_a_sel    = v.asel;
    bus.fwd_b_sel    = v.bsel;
    bus.fwd_mem_data = v.mem;
    bus.fwd_wb_data  = v.wb;
    bus.br_type_Ex   = v.br;
    bus.stall        = v.ctl[3];
    bus.flush_Ex     = v.ctl[2];
    bus.SaveFlags_Ex = v.ctl[1];
    bus.returnF_Ex   = v.ctl[0];
  endtask

  task automatic run_table(input int pass);
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("p%0d v%0d alu_out", pass, i), bus.alu_out_Ex, vecs[i].e_out);
      chk($sformatf("p%0d v%0d op_b", pass, i), bus.op_b_Ex, vecs[i].e_opb);
      chk($sformatf("p%0d v%0d target", pass, i), bus.branch_target, vecs[i].e_opb);
      chk($sformatf("p%0d v%0d taken", pass, i), {7'd0, bus.branch_taken}, {7'd0, vecs[i].e_taken});
      @(posedge clk);
      #1;
      chk($sformatf("p%0d v%0d ccr", pass, i), {4'd0, bus.ccr}, {4'd0, vecs[i].e_ccr});
      chk($sformatf("p%0d v%0d saved", pass, i), {4'd0, bus.saved_ccr}, {4'd0, vecs[i].e_saved});
      $display("pass %0d vec %2d op=%0d a=%02h b=%02h br=%0d ctl=%b -> out=%02h tk=%0d ccr=%b saved=%b",
               pass, i, vecs[i].op, vecs[i].ra, vecs[i].rb, vecs[i].br, vecs[i].ctl,
               bus.alu_out_Ex, bus.branch_taken, bus.ccr, bus.saved_ccr);
    end
  endtask

  initial begin
    //              op  ra     rb     as bs mem    wb     br ctl      out    opb   tk ccr      saved
    vecs[0]  = mk(2, 8'h7F, 8'h01, 0, 0, 8'h00, 8'h00, 0, 4'b0000, 8'h80, 8'h01, 0, 4'b1010, 4'b0000);
    vecs[1]  = mk(2, 8'hFF, 8'h01, 0, 0, 8'h00, 8'h00, 0, 4'b0000, 8'h00, 8'h01, 0, 4'b0101, 4'b0000);
    vecs[2]  = mk(6, 8'h00, 8'h80, 0, 0, 8'h00, 8'h00, 0, 4'b0000, 8'h01, 8'h80, 0, 4'b0101, 4'b0000);
    vecs[3]  = mk(3, 8'h03, 8'h05, 0, 0, 8'h00, 8'h00, 0, 4'b0000, 8'hFE, 8'h05, 0, 4'b0110, 4'b0000);
    vecs[4]  = mk(2, 8'h00, 8'h00, 1, 2, 8'h10, 8'h22, 0, 4'b0000, 8'h32, 8'h22, 0, 4'b0000, 4'b0000);
    vecs[5]  = mk(3, 8'h05, 8'h05, 0, 0, 8'h00, 8'h00, 0, 4'b0000, 8'h00, 8'h05, 0, 4'b0001, 4'b0000);
    vecs[6]  = mk(0, 8'h33, 8'h40, 0, 0, 8'h00, 8'h00, 1, 4'b0000, 8'h33, 8'h40, 1, 4'b0000, 4'b0000);
    vecs[7]  = mk(3, 8'h07, 8'h07, 0, 0, 8'h00, 8'h00, 0, 4'b0000, 8'h00, 8'h07, 0, 4'b0001, 4'b0000);
    vecs[8]  = mk(2, 8'h01, 8'h01, 0, 0, 8'h00, 8'h00, 1, 4'b0100, 8'h02, 8'h01, 0, 4'b0001, 4'b0000);
    vecs[9]  = mk(0, 8'h00, 8'h99, 0, 0, 8'h00, 8'h00, 5, 4'b0000, 8'h00, 8'h99, 1, 4'b0001, 4'b0000);
    vecs[10] = mk(3, 8'h03, 8'h05, 0, 0, 8'h00, 8'h00, 0, 4'b0000, 8'hFE, 8'h05, 0, 4'b0110, 4'b0000);
    vecs[11] = mk(0, 8'h11, 8'h00, 0, 0, 8'h00, 8'h00, 0, 4'b0010, 8'h11, 8'h00, 0, 4'b0110, 4'b0110);
    vecs[12] = mk(2, 8'h01, 8'h02, 0, 0, 8'h00, 8'h00, 0, 4'b0000, 8'h03, 8'h02, 0, 4'b0000, 4'b0110);
    vecs[13] = mk(2, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 4'b0000, 8'h00, 8'h00, 0, 4'b0001, 4'b0110);
    vecs[14] = mk(2, 8'hFF, 8'h01, 0, 0, 8'h00, 8'h00, 0, 4'b0001, 8'h00, 8'h01, 0, 4'b0110, 4'b0110);
    vecs[15] = mk(2, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 4'b0000, 8'h00, 8'h00, 0, 4'b0001, 4'b0110);
    vecs[16] = mk(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 4'b0011, 8'h00, 8'h00, 0, 4'b0110, 4'b0001);
    vecs[17] = mk(9, 8'h00, 8'h5A, 0, 0, 8'h00, 8'h00, 0, 4'b1011, 8'h5A, 8'h5A, 0, 4'b0110, 4'b0001);
    vecs[18] = mk(9, 8'h00, 8'h5A, 0, 0, 8'h00, 8'h00, 0, 4'b0000, 8'h5A, 8'h5A, 0, 4'b0010, 4'b0001);
    vecs[19] = mk(4, 8'hF0, 8'h0F, 0, 0, 8'h00, 8'h00, 0, 4'b0000, 8'h00, 8'h0F, 0, 4'b0001, 4'b0001);
    vecs[20] = mk(5, 8'h80, 8'h01, 0, 0, 8'h00, 8'h00, 0, 4'b0000, 8'h81, 8'h01, 0, 4'b0010, 4'b0001);
    vecs[21] = mk(10, 8'h00, 8'hFF, 0, 0, 8'h00, 8'h00, 0, 4'b0000, 8'h00, 8'hFF, 0, 4'b0001, 4'b0001);
    vecs[22] = mk(11, 8'h00, 8'h01, 0, 0, 8'h00, 8'h00, 0, 4'b0000, 8'hFF, 8'h01, 0, 4'b0010, 4'b0001);
    vecs[23] = mk(8, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 4'b0000, 8'h00, 8'h00, 0, 4'b0110, 4'b0001);
    vecs[24] = mk(7, 8'h00, 8'h02, 0, 0, 8'h00, 8'h00, 0, 4'b0000, 8'h81, 8'h02, 0, 4'b0010, 4'b0001);
    vecs[25] = mk(12, 8'h00, 8'h7F, 0, 0, 8'h00, 8'h00, 0, 4'b0000, 8'h80, 8'h7F, 0, 4'b1010, 4'b0001);
    vecs[26] = mk(12, 8'h00, 8'hFF, 0, 0, 8'h00, 8'h00, 0, 4'b0000, 8'h00, 8'hFF, 0, 4'b0101, 4'b0001);
    vecs[27] = mk(13, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 4'b0000, 8'hFF, 8'h00, 0, 4'b0110, 4'b0001);
    vecs[28] = mk(13, 8'h00, 8'h80, 0, 0, 8'h00, 8'h00, 0, 4'b0000, 8'h7F, 8'h80, 0, 4'b1000, 4'b0001);
    vecs[29] = mk(0, 8'h01, 8'h00, 0, 0, 8'h00, 8'h00, 4, 4'b0000, 8'h01, 8'h00, 1, 4'b0000, 4'b0001);
    vecs[30] = mk(14, 8'h44, 8'h00, 3, 0, 8'h55, 8'h00, 0, 4'b0000, 8'h44, 8'h00, 0, 4'b0000, 4'b0001);
    vecs[31] = mk(0, 8'h00, 8'h12, 0, 0, 8'h00, 8'h00, 3, 4'b0000, 8'h00, 8'h12, 0, 4'b0000, 4'b0001);
    vecs[32] = mk(10, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 4'b0000, 8'hFF, 8'h00, 0, 4'b0010, 4'b0001);
    vecs[33] = mk(10, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 2, 4'b0000, 8'hFF, 8'h00, 1, 4'b0000, 4'b0001);
    vecs[34] = mk(2, 8'hFF, 8'h01, 0, 0, 8'h00, 8'h00, 0, 4'b0000, 8'h00, 8'h01, 0, 4'b0101, 4'b0001);
    vecs[35] = mk(2, 8'h01, 8'h01, 0, 0, 8'h00, 8'h00, 0, 4'b0101, 8'h02, 8'h01, 0, 4'b0101, 4'b0001);

    // Power-on reset with idle inputs
    drive(mk(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 4'b0000, 8'h00, 8'h00, 0, 4'b0000, 4'b0000));
    repeat (2) @(posedge clk);
    #1;
    chk("reset ccr", {4'd0, bus.ccr}, 8'h00);
    chk("reset saved", {4'd0, bus.saved_ccr}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    run_table(0);

    // Asynchronous reset between edges while stalled, with live ALU inputs
    @(negedge clk);
    drive(mk(2, 8'h03, 8'h04, 0, 0, 8'h00, 8'h00, 0, 4'b1000, 8'h00, 8'h00, 0, 4'b0000, 4'b0000));
    #2;
    chk("pre-reset ccr", {4'd0, bus.ccr}, 8'h05);
    rst_n = 1'b0;
    #1;
    chk("async ccr", {4'd0, bus.ccr}, 8'h00);
    chk("async saved", {4'd0, bus.saved_ccr}, 8'h00);
    chk("reset alu_out", bus.alu_out_Ex, 8'h07);
    $display("async reset asserted mid-stall: ccr=%b saved=%b", bus.ccr, bus.saved_ccr);
    @(posedge clk);
    #1;
    chk("held ccr", {4'd0, bus.ccr}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    run_table(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
Execute stage that consumes the ID/EX pipeline register outputs. It selects forwarded operands, computes the 8-bit ALU result, and owns the condition-code register (CCR). It also saves and restores flags around interrupts and resolves conditional jumps. The ALU result and branch decision feed the EX/MEM register and the PC logic.

Parameters:
WIDTH, 8, datapath width
FLAGS_W, 4, CCR width, ordered {V,C,N,Z}

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  hold CCR and saved flags
flush_Ex  in  1  instruction in EX is squashed
Alu_Op_Ex  in  4  ALU opcode
SaveFlags_Ex  in  1  copy CCR into saved-flags register
returnF_Ex  in  1  restore CCR from saved-flags register
br_type_Ex  in  3  0 none, 1 JZ, 2 JN, 3 JC, 4 JV, 5 JMP
R_ra_Ex  in  8  operand A from register file
R_rb_Ex  in  8  operand B from register file
fwd_a_sel  in  2  operand A source: 0 R_ra_Ex, 1 fwd_mem_data, 2 fwd_wb_data, 3 R_ra_Ex
fwd_b_sel  in  2  operand B source, same encoding as fwd_a_sel
fwd_mem_data  in  8  forwarded value from EX/MEM
fwd_wb_data  in  8  forwarded value from MEM/WB
alu_out_Ex  out  8  ALU result (combinational)
op_b_Ex  out  8  forwarded operand B, used for store data
ccr  out  4  current flags {V,C,N,Z} (registered)
saved_ccr  out  4  saved flags (registered)
branch_taken  out  1  redirect PC (combinational)
branch_target  out  8  equals forwarded operand B

Behaviour:
- Reset (rst_n=0, asynchronous): ccr=0 and saved_ccr=0 immediately. Combinational outputs follow their inputs.
- A = fwd_a_sel mux, B = fwd_b_sel mux. Cin = ccr[2].
- Opcodes and flag updates ("-" = flag unchanged):
  - 0 PASS: out=A; flags -
  - 1 MOV: out=B; flags -
  - 2 ADD: out=A+B; Z N C V updated; C is carry out of bit 7; V is signed overflow.
  - 3 SUB: out=A-B; Z N C V updated; C=1 iff A<B unsigned (borrow).
  - 4 AND: out=A&B; Z N updated.
  - 5 OR: out=A|B; Z N updated.
  - 6 RLC: out={B[6:0],Cin}; C=B[7].
  - 7 RRC: out={Cin,B[7:1]}; C=B[0].
  - 8 SETC: C=1; out=B.
  - 9 CLRC: C=0; out=B.
  - 10 NOT: out=~B; Z N updated.
  - 11 NEG: out=0-B; Z N updated.
  - 12 INC: out=B+1; Z N C V updated.
  - 13 DEC: out=B-1; Z N C V updated; C=1 on borrow (B=0).
  - 14, 15: out=A; flags -
- Z = (out==0). N = out[7]. All arithmetic is modulo 256.
- Branch condition: JZ uses Z, JN uses N, JC uses C, JV uses V; JMP is always taken.
  - branch_taken = condition true && !flush_Ex.
  - A taken conditional jump clears its tested flag at the next edge.
- Per-edge CCR update priority:
  1. stall=1: hold ccr and saved_ccr.
  2. flush_Ex=1: hold ccr. saved_ccr still holds because SaveFlags is ignored.
  3. returnF_Ex=1: ccr <= saved_ccr. The ALU and branch flag effects of this cycle are discarded.
  4. Otherwise: ccr <= ALU flag update, then branch flag clear applied on top. The clear wins on the same flag.
- SaveFlags_Ex=1 (not stalled, not flushed): saved_ccr <= ccr as it was before this edge.
  - With returnF_Ex also 1, the two swap: saved_ccr gets the old ccr, ccr gets the old saved_ccr.
- Latency: alu_out and branch_taken are zero-cycle. ccr changes one cycle later and is visible to the next instruction's Cin and branch tests.
- Reset asserted mid-stall or mid-interrupt clears both registers. There is no pending state.

Test Plan:
- Reset: drive rst_n low asynchronously between edges -> ccr=0 and saved_ccr=0 immediately; after release, ADD 0x7F+0x01 -> alu_out=0x80, next ccr={V1,C0,N1,Z0}=4'b1010.
- Carry and subtract: ADD 0xFF+0x01 -> out=0x00, ccr=4'b0101. Then RLC B=0x80 with Cin=1 -> out=0x01, C=1. SUB 0x03-0x05 -> out=0xFE, C=1, N=1.
- Forwarding: fwd_a_sel=1 with fwd_mem_data=0x10, fwd_b_sel=2 with fwd_wb_data=0x22, R_ra/R_rb=0 -> ADD out=0x32, op_b_Ex=0x22.
- Branch: ccr Z=1, JZ -> branch_taken=1, branch_target=B, next ccr Z=0. Same with flush_Ex=1 -> branch_taken=0, ccr unchanged.
- Interrupt flags: ccr=4'b0110, SaveFlags -> saved_ccr=0110. ADD producing 0000 then 0001. returnF -> ccr=0110. SaveFlags+returnF together -> values swap.
- Stall: stall=1 during SETC, SaveFlags and returnF -> ccr and saved_ccr unchanged; release stall -> updates resume.
